// File: rtl/ysyx_2022040010_regfile_mp.sv
// Multi-port integer register file with write-to-read bypass and a per-register busy scoreboard.
// Reg 0 reads as zero; issue marks a destination busy, write-back clears it, flush drops all producers.
module ysyx_2022040010_regfile_mp #(
   parameter int XLEN  = 64,
   parameter int NREGS = 32,
   parameter int AW    = $clog2(NREGS),
   parameter int NRD   = 2,
   parameter int NWR   = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NWR-1:0]      we,
   input  logic [NWR*AW-1:0]   waddr,
   input  logic [NWR*XLEN-1:0] wdata,
   input  logic [NRD-1:0]      re,
   input  logic [NRD*AW-1:0]   raddr,
   output logic [NRD*XLEN-1:0] rdata,
   output logic [NRD-1:0]      rvalid,
   input  logic                iss_valid,
   input  logic [AW-1:0]       iss_rd,
   input  logic                flush,
   output logic [NREGS-1:0]    busy
);

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [XLEN-1:0]  regs_d [NREGS];
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;

   // Ascending port order lets the highest-index port win a same-address collision.
   always_comb begin
      for (int r = 0; r < NREGS; r++) begin
         regs_d[r] = regs_q[r];
      end
      for (int k = 0; k < NWR; k++) begin
         if (we[k] && (waddr[k*AW +: AW] != '0) && (int'(waddr[k*AW +: AW]) < NREGS)) begin
            regs_d[waddr[k*AW +: AW]] = wdata[k*XLEN +: XLEN];
         end
      end
      regs_d[0] = '0;
   end

   always_comb begin
      busy_d = busy_q;
      if (flush) begin
         busy_d = '0;
      end else begin
         for (int k = 0; k < NWR; k++) begin
            if (we[k] && (int'(waddr[k*AW +: AW]) < NREGS)) begin
               busy_d[waddr[k*AW +: AW]] = 1'b0;
            end
         end
         // A new producer supersedes a write-back of the old one to the same register.
         if (iss_valid && (iss_rd != '0) && (int'(iss_rd) < NREGS)) begin
            busy_d[iss_rd] = 1'b1;
         end
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < NREGS; r++) begin
            regs_q[r] <= '0;
         end
         busy_q <= '0;
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            regs_q[r] <= regs_d[r];
         end
         busy_q <= busy_d;
      end
   end

   assign busy = busy_q;

   genvar gi;
   generate
      for (gi = 0; gi < NRD; gi++) begin : g_rd
         logic [AW-1:0]   ra;
         logic [XLEN-1:0] rd_val;
         logic            rd_ok;

         assign ra = raddr[gi*AW +: AW];

         always_comb begin
            rd_val = '0;
            rd_ok  = 1'b0;
            if (!rst || !re[gi]) begin
               rd_val = '0;
               rd_ok  = 1'b0;
            end else if (ra == '0) begin
               rd_ok = 1'b1;
            end else begin
               if (int'(ra) < NREGS) begin
                  rd_val = regs_q[ra];
                  rd_ok  = !busy_q[ra];
               end
               // Bypass from write-back: the value being written is current, whatever busy says.
               for (int k = 0; k < NWR; k++) begin
                  if (we[k] && (waddr[k*AW +: AW] == ra)) begin
                     rd_val = wdata[k*XLEN +: XLEN];
                     rd_ok  = 1'b1;
                  end
               end
            end
         end

         assign rdata[gi*XLEN +: XLEN] = rd_val;
         assign rvalid[gi]             = rd_ok;
      end
   endgenerate

endmodule
